// File: rtl/inst_mem_arbiter_if.sv
// inst_mem_arbiter_if: IF/LS request, response and memory-side signals of the instruction memory arbiter
interface inst_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_rready;
  logic              ls_req;
  logic [ADDR_W-1:0] ls_addr;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_err;
  logic              mem_ce;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_inst;
  modport slave (
    input  if_req, if_addr, if_flush, if_rready, ls_req, ls_addr, mem_inst,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err, mem_ce, mem_addr
  );
  modport master (
    output if_req, if_addr, if_flush, if_rready, ls_req, ls_addr, mem_inst,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err, mem_ce, mem_addr
  );
endinterface

// File: rtl/inst_mem_arbiter.sv
// inst_mem_arbiter: shares one combinational instruction memory between fetch (IF) and load (LS) ports with LS priority and IF starvation guard
module inst_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst,
  inst_mem_arbiter_if.slave bus
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;
  logic if_elig, if_win, ls_mis, ls_rd;
  always_comb begin
    if_elig = bus.if_req & ~bus.if_flush & (~bus.if_rvalid | bus.if_rready);
    if_win = if_elig & (~bus.ls_req | (starve_cnt == LIM));
    bus.if_gnt = ~rst & if_win;
    bus.ls_gnt = ~rst & bus.ls_req & ~if_win;
    ls_mis = bus.ls_addr[1:0] != 2'b00;
    ls_rd = bus.ls_gnt & ~ls_mis;
    bus.mem_ce = bus.if_gnt | ls_rd;
    bus.mem_addr = bus.if_gnt ? bus.if_addr : ls_rd ? bus.ls_addr : {ADDR_W{1'b0}};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
      bus.if_rvalid <= 1'b0;
      bus.if_rdata <= {DATA_W{1'b0}};
      bus.ls_rvalid <= 1'b0;
      bus.ls_rdata <= {DATA_W{1'b0}};
      bus.ls_err <= 1'b0;
    end else begin
      starve_cnt <= (bus.if_gnt | ~if_elig) ? 4'd0 : (bus.ls_gnt & (starve_cnt != LIM)) ? starve_cnt + 4'd1 : starve_cnt;
      bus.if_rvalid <= ~bus.if_flush & (bus.if_gnt | (bus.if_rvalid & ~bus.if_rready));
      bus.if_rdata <= bus.if_gnt ? bus.mem_inst : bus.if_rdata;
      bus.ls_rvalid <= bus.ls_gnt;
      bus.ls_rdata <= ls_rd ? bus.mem_inst : {DATA_W{1'b0}};
      bus.ls_err <= bus.ls_gnt & ls_mis;
    end
  end
endmodule

// File: tb/tb_inst_mem_arbiter.sv
// tb_inst_mem_arbiter: directed self-checking bench for inst_mem_arbiter
module tb_inst_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  inst_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  inst_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_inst = bus.mem_ce ? {16'hC0DE, bus.mem_addr[17:2]} : 32'hDEADBEEF;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h0;
    bus.if_flush = 1'b0;
    bus.if_rready = 1'b1;
    bus.ls_req = 1'b1;
    bus.ls_addr = 32'h200;
    cyc();
    cyc();
    chk("rst_if_gnt", 64'(bus.if_gnt), 64'd0);
    chk("rst_ls_gnt", 64'(bus.ls_gnt), 64'd0);
    chk("rst_mem_ce", 64'(bus.mem_ce), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_if_rvalid", 64'(bus.if_rvalid), 64'd0);
    chk("rst_if_rdata", 64'(bus.if_rdata), 64'd0);
    chk("rst_ls_rvalid", 64'(bus.ls_rvalid), 64'd0);
    chk("rst_ls_rdata", 64'(bus.ls_rdata), 64'd0);
    chk("rst_ls_err", 64'(bus.ls_err), 64'd0);
    rst = 1'b0;
    bus.ls_req = 1'b0;
    bus.if_addr = 32'h0;
    #1;
    chk("ifo0_gnt", 64'(bus.if_gnt), 64'd1);
    chk("ifo0_ce", 64'(bus.mem_ce), 64'd1);
    chk("ifo0_addr", 64'(bus.mem_addr), 64'h0);
    cyc();
    bus.if_addr = 32'h4;
    #1;
    chk("ifo1_gnt", 64'(bus.if_gnt), 64'd1);
    chk("ifo1_addr", 64'(bus.mem_addr), 64'h4);
    chk("ifo1_rvalid", 64'(bus.if_rvalid), 64'd1);
    chk("ifo1_rdata", 64'(bus.if_rdata), 64'hC0DE0000);
    cyc();
    bus.if_addr = 32'h8;
    #1;
    chk("ifo2_gnt", 64'(bus.if_gnt), 64'd1);
    chk("ifo2_rvalid", 64'(bus.if_rvalid), 64'd1);
    chk("ifo2_rdata", 64'(bus.if_rdata), 64'hC0DE0001);
    cyc();
    bus.if_req = 1'b0;
    #1;
    chk("ifo3_gnt", 64'(bus.if_gnt), 64'd0);
    chk("ifo3_ce", 64'(bus.mem_ce), 64'd0);
    chk("ifo3_addr", 64'(bus.mem_addr), 64'd0);
    chk("ifo3_rvalid", 64'(bus.if_rvalid), 64'd1);
    chk("ifo3_rdata", 64'(bus.if_rdata), 64'hC0DE0002);
    cyc();
    chk("ifo4_rvalid", 64'(bus.if_rvalid), 64'd0);
    bus.if_req = 1'b1;
    bus.if_addr = 32'h100;
    bus.ls_req = 1'b1;
    bus.ls_addr = 32'h200;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("cont%0d_if_gnt", k), 64'(bus.if_gnt), 64'(k % 5 == 4));
      chk($sformatf("cont%0d_ls_gnt", k), 64'(bus.ls_gnt), 64'(k % 5 != 4));
      chk($sformatf("cont%0d_addr", k), 64'(bus.mem_addr), (k % 5 == 4) ? 64'h100 : 64'h200);
      chk($sformatf("cont%0d_if_rvalid", k), 64'(bus.if_rvalid), 64'(k == 5));
      chk($sformatf("cont%0d_ls_rvalid", k), 64'(bus.ls_rvalid), 64'(k > 0 && k != 5));
      cyc();
    end
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    cyc();
    cyc();
    bus.if_rready = 1'b0;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h20;
    #1;
    chk("bp0_gnt", 64'(bus.if_gnt), 64'd1);
    cyc();
    bus.if_addr = 32'h24;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_hold%0d_gnt", k), 64'(bus.if_gnt), 64'd0);
      chk($sformatf("bp_hold%0d_rvalid", k), 64'(bus.if_rvalid), 64'd1);
      chk($sformatf("bp_hold%0d_rdata", k), 64'(bus.if_rdata), 64'hC0DE0008);
      cyc();
    end
    bus.if_rready = 1'b1;
    #1;
    chk("bp_drain_gnt", 64'(bus.if_gnt), 64'd1);
    chk("bp_drain_addr", 64'(bus.mem_addr), 64'h24);
    cyc();
    bus.if_req = 1'b0;
    #1;
    chk("bp_next_rvalid", 64'(bus.if_rvalid), 64'd1);
    chk("bp_next_rdata", 64'(bus.if_rdata), 64'hC0DE0009);
    cyc();
    chk("bp_empty_rvalid", 64'(bus.if_rvalid), 64'd0);
    bus.if_rready = 1'b0;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h10;
    #1;
    chk("fl0_gnt", 64'(bus.if_gnt), 64'd1);
    cyc();
    bus.if_flush = 1'b1;
    bus.if_rready = 1'b1;
    bus.ls_req = 1'b1;
    bus.ls_addr = 32'h40;
    #1;
    chk("fl1_if_gnt", 64'(bus.if_gnt), 64'd0);
    chk("fl1_ls_gnt", 64'(bus.ls_gnt), 64'd1);
    chk("fl1_addr", 64'(bus.mem_addr), 64'h40);
    chk("fl1_rvalid", 64'(bus.if_rvalid), 64'd1);
    cyc();
    bus.if_flush = 1'b0;
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    #1;
    chk("fl2_if_rvalid", 64'(bus.if_rvalid), 64'd0);
    chk("fl2_ls_rvalid", 64'(bus.ls_rvalid), 64'd1);
    chk("fl2_ls_rdata", 64'(bus.ls_rdata), 64'hC0DE0010);
    chk("fl2_ls_err", 64'(bus.ls_err), 64'd0);
    cyc();
    chk("fl3_ls_rvalid", 64'(bus.ls_rvalid), 64'd0);
    chk("fl3_if_rvalid", 64'(bus.if_rvalid), 64'd0);
    bus.ls_req = 1'b1;
    bus.ls_addr = 32'h6;
    #1;
    chk("mis_gnt", 64'(bus.ls_gnt), 64'd1);
    chk("mis_ce", 64'(bus.mem_ce), 64'd0);
    cyc();
    bus.ls_req = 1'b0;
    #1;
    chk("mis_rvalid", 64'(bus.ls_rvalid), 64'd1);
    chk("mis_err", 64'(bus.ls_err), 64'd1);
    chk("mis_rdata", 64'(bus.ls_rdata), 64'd0);
    cyc();
    bus.if_rready = 1'b0;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h30;
    cyc();
    chk("rs0_rvalid", 64'(bus.if_rvalid), 64'd1);
    rst = 1'b1;
    bus.ls_req = 1'b1;
    bus.ls_addr = 32'h44;
    #1;
    chk("rs0_if_gnt", 64'(bus.if_gnt), 64'd0);
    chk("rs0_ls_gnt", 64'(bus.ls_gnt), 64'd0);
    chk("rs0_ce", 64'(bus.mem_ce), 64'd0);
    cyc();
    chk("rs1_if_rvalid", 64'(bus.if_rvalid), 64'd0);
    chk("rs1_ls_rvalid", 64'(bus.ls_rvalid), 64'd0);
    rst = 1'b0;
    bus.if_rready = 1'b1;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h100;
    bus.ls_addr = 32'h200;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("pre%0d_ls_gnt", k), 64'(bus.ls_gnt), 64'd1);
      cyc();
    end
    rst = 1'b1;
    #1;
    chk("rs2_ls_rvalid", 64'(bus.ls_rvalid), 64'd1);
    chk("rs2_ls_gnt", 64'(bus.ls_gnt), 64'd0);
    chk("rs2_if_gnt", 64'(bus.if_gnt), 64'd0);
    cyc();
    chk("rs3_ls_rvalid", 64'(bus.ls_rvalid), 64'd0);
    chk("rs3_if_rvalid", 64'(bus.if_rvalid), 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("post%0d_if_gnt", k), 64'(bus.if_gnt), 64'(k == 4));
      chk($sformatf("post%0d_ls_gnt", k), 64'(bus.ls_gnt), 64'(k != 4));
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
